// File: rtl/modulo_scheduler_pkg.sv
// Shared constants and helpers for the round-robin modulo scheduler.
package modulo_sched_pkg;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   // Index width for a client count; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/modulo_scheduler_if.sv
// Request/operand/result bundle between the clients and the modulo scheduler.
interface modulo_scheduler_if
   import modulo_sched_pkg::*;
#(
   parameter int SIZE    = 16,
   parameter int CLIENTS = 4,
   parameter int IDX_W   = idx_w(CLIENTS)
);

   logic [CLIENTS-1:0]      req;
   logic [CLIENTS*SIZE-1:0] divident;
   logic [CLIENTS*SIZE-1:0] divisor;
   logic [CLIENTS-1:0]      ack;
   logic [CLIENTS-1:0]      rvalid;
   logic [SIZE-1:0]         remainder;
   logic                    div_zero;
   logic                    busy;
   logic [IDX_W-1:0]        owner;

   modport master (
      output req, divident, divisor,
      input  ack, rvalid, remainder, div_zero, busy, owner
   );

   modport slave (
      input  req, divident, divisor,
      output ack, rvalid, remainder, div_zero, busy, owner
   );

endinterface

// File: rtl/modulo_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting client at or above the
// pointer, wrapping around.
module rr_arbiter
   import modulo_sched_pkg::*;
#(
   parameter int CLIENTS = 4,
   parameter int IDX_W   = idx_w(CLIENTS)
) (
   input  logic [CLIENTS-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               valid_o
);

   always_comb begin
      int idx;
      winner_o = {IDX_W{1'b0}};
      valid_o  = 1'b0;
      idx      = 0;
      for (int i = 0; i < CLIENTS; i++) begin
         idx      = (int'(ptr_i) + i) % CLIENTS;
         winner_o = (!valid_o && req_i[idx]) ? IDX_W'(idx) : winner_o;
         valid_o  = valid_o | req_i[idx];
      end
   end

endmodule

// File: rtl/modulo_scheduler.sv
// One repeated-subtraction modulo engine shared by CLIENTS requesters under
// round-robin arbitration; divide-by-zero is answered in the grant cycle.
module modulo_scheduler
   import modulo_sched_pkg::*;
#(
   parameter int SIZE    = 16,
   parameter int CLIENTS = 4
) (
   input  logic             clk,
   input  logic             rst,
   modulo_scheduler_if.slave bus
);

   localparam int IDX_W = idx_w(CLIENTS);

   logic [0:0]         state_q,  state_d;
   logic [IDX_W-1:0]   ptr_q,    ptr_d;
   logic [IDX_W-1:0]   owner_q,  owner_d;
   logic [SIZE-1:0]    step_q,   step_d;
   logic [SIZE-1:0]    dreg_q,   dreg_d;
   logic [SIZE-1:0]    rem_q,    rem_d;
   logic               dz_q,     dz_d;
   logic [CLIENTS-1:0] ack_q,    ack_d;
   logic [CLIENTS-1:0] rvalid_q, rvalid_d;

   logic [IDX_W-1:0]   win_s;
   logic               win_valid_s;
   logic [SIZE-1:0]    win_dvd_s;
   logic [SIZE-1:0]    win_dsr_s;
   logic [SIZE:0]      diff_s;

   rr_arbiter #(
      .CLIENTS (CLIENTS),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .winner_o (win_s),
      .valid_o  (win_valid_s)
   );

   assign win_dvd_s = bus.divident[int'(win_s)*SIZE +: SIZE];
   assign win_dsr_s = bus.divisor[int'(win_s)*SIZE +: SIZE];

   // The extra top bit is the borrow: set once step has dropped below the divisor.
   assign diff_s = {1'b0, step_q} - {1'b0, dreg_q};

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      step_d   = step_q;
      dreg_d   = dreg_q;
      rem_d    = rem_q;
      dz_d     = dz_q;
      ack_d    = {CLIENTS{1'b0}};
      rvalid_d = {CLIENTS{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (win_valid_s) begin
               owner_d       = win_s;
               step_d        = win_dvd_s;
               dreg_d        = win_dsr_s;
               ack_d[win_s]  = 1'b1;
               ptr_d         = (win_s == IDX_W'(CLIENTS - 1)) ? {IDX_W{1'b0}} : win_s + IDX_W'(1);
               if (win_dsr_s == {SIZE{1'b0}}) begin
                  rvalid_d[win_s] = 1'b1;
                  rem_d           = win_dvd_s;
                  dz_d            = 1'b1;
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (!diff_s[SIZE]) begin
               step_d = diff_s[SIZE-1:0];
            end else begin
               rem_d             = step_q;
               rvalid_d[owner_q] = 1'b1;
               dz_d              = 1'b0;
               state_d           = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= {IDX_W{1'b0}};
         owner_q  <= {IDX_W{1'b0}};
         step_q   <= {SIZE{1'b0}};
         dreg_q   <= {SIZE{1'b0}};
         rem_q    <= {SIZE{1'b0}};
         dz_q     <= 1'b0;
         ack_q    <= {CLIENTS{1'b0}};
         rvalid_q <= {CLIENTS{1'b0}};
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         step_q   <= step_d;
         dreg_q   <= dreg_d;
         rem_q    <= rem_d;
         dz_q     <= dz_d;
         ack_q    <= ack_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = dz_q;
   assign bus.busy      = (state_q == S_CALC);
   assign bus.owner     = owner_q;

endmodule
